// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers for the synchronous FIFO and its storage RAM.
//   fifo_ptr_width(depth) : width of a wrap-aware FIFO pointer, i.e. the
//                           address width plus one extra lap bit.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  function automatic int unsigned fifo_ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_dp_ram.sv
// -----------------------------------------------------------------------------
// dp_ram
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Ports:
//   clk      : write clock (rising edge)
//   wr_en    : write strobe, wr_data is stored at wr_addr on the clock edge
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable; rd_data reads as zero while low
//   rd_addr  : read address
//   rd_data  : combinational read data of the entry at rd_addr
// -----------------------------------------------------------------------------
module dp_ram
  import sync_fifo_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH = 8,
  parameter int OPTN_RAM_DEPTH  = 8,
  localparam int ADDR_W         = fifo_ptr_width(OPTN_RAM_DEPTH) - 1
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [OPTN_DATA_WIDTH-1:0] wr_data,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [OPTN_DATA_WIDTH-1:0] rd_data
);

  logic [OPTN_DATA_WIDTH-1:0] mem_q [OPTN_RAM_DEPTH];

  // NOTE: storage arrays are deliberately not reset; only the pointers that
  // qualify their contents are, which keeps the array mappable to RAM cells.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_en ? mem_q[rd_addr] : '0;

endmodule : dp_ram

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with valid/ready handshakes on both sides. Storage lives in
// a dp_ram; head/tail pointers carry one extra lap bit so that full and empty
// are distinguishable without a separate counter.
//
// Optional feature macro: SYNC_FIFO_ALMOST_FULL_EN
//   When defined, adds o_fifo_almost_full = (count >= OPTN_AF_THRESHOLD).
//
// Ports:
//   clk                : rising-edge clock for all state
//   rst                : synchronous, active-high reset (pointers to zero)
//   i_fifo_flush       : synchronous clear of all entries, overrides push/pop
//   i_fifo_push_valid  : producer offers i_fifo_push_data
//   o_fifo_push_ready  : FIFO is not full
//   i_fifo_push_data   : entry to push
//   o_fifo_pop_valid   : FIFO is not empty, o_fifo_pop_data is the head
//   i_fifo_pop_ready   : consumer takes the head entry
//   o_fifo_pop_data    : head entry (don't-care while empty)
//   o_fifo_almost_full : occupancy at or above threshold (macro only)
//   o_fifo_count       : occupancy, 0..OPTN_FIFO_DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH   = 8,
  parameter int OPTN_FIFO_DEPTH   = 8,
  parameter int OPTN_AF_THRESHOLD = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_fifo_flush,
  input  logic                               i_fifo_push_valid,
  output logic                               o_fifo_push_ready,
  input  logic [OPTN_DATA_WIDTH-1:0]         i_fifo_push_data,
  output logic                               o_fifo_pop_valid,
  input  logic                               i_fifo_pop_ready,
  output logic [OPTN_DATA_WIDTH-1:0]         o_fifo_pop_data,
`ifdef SYNC_FIFO_ALMOST_FULL_EN
  output logic                               o_fifo_almost_full,
`endif
  output logic [$clog2(OPTN_FIFO_DEPTH):0]   o_fifo_count
);

  localparam int PTR_W  = fifo_ptr_width(OPTN_FIFO_DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  // Elaboration-time sanity checks on the configuration.
  if (OPTN_FIFO_DEPTH < 2 || (OPTN_FIFO_DEPTH & (OPTN_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: OPTN_FIFO_DEPTH must be a power of two and >= 2");
  end
  if (OPTN_AF_THRESHOLD < 0 || OPTN_AF_THRESHOLD > OPTN_FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo: OPTN_AF_THRESHOLD must lie in 0..OPTN_FIFO_DEPTH");
  end

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Status comes only from registered pointers, so ready/valid outputs never
  // depend combinationally on the handshake inputs.
  assign empty = (head_q == tail_q);
  assign full  = (head_q[ADDR_W] != tail_q[ADDR_W]) &&
                 (head_q[ADDR_W-1:0] == tail_q[ADDR_W-1:0]);

  assign o_fifo_push_ready = !full;
  assign o_fifo_pop_valid  = !empty;

  // Flush squashes the write so the RAM is left untouched that cycle.
  assign push = i_fifo_push_valid && o_fifo_push_ready && !i_fifo_flush;
  assign pop  = o_fifo_pop_valid  && i_fifo_pop_ready;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (i_fifo_flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      // Depth is a power of two, so the low bits wrap DEPTH-1 -> 0 and the
      // MSB toggles naturally on each lap.
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Modulo subtraction of the lap-extended pointers yields 0..DEPTH.
  assign o_fifo_count = tail_q - head_q;

`ifdef SYNC_FIFO_ALMOST_FULL_EN
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(OPTN_AF_THRESHOLD);
  assign o_fifo_almost_full = (o_fifo_count >= AF_THR);
`endif

  dp_ram #(
    .OPTN_DATA_WIDTH (OPTN_DATA_WIDTH),
    .OPTN_RAM_DEPTH  (OPTN_FIFO_DEPTH)
  ) u_dp_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (tail_q[ADDR_W-1:0]),
    .wr_data (i_fifo_push_data),
    .rd_en   (1'b1),
    .rd_addr (head_q[ADDR_W-1:0]),
    .rd_data (o_fifo_pop_data)
  );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Self-checking bench for sync_fifo (DEPTH=8, WIDTH=8, AF threshold 6).
// A queue-based reference model tracks the expected contents; a vector table
// covers fill/overflow/drain, hand sequences cover latency, wrap, flush and
// reset, and a randomized phase exercises mixed traffic.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AF    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_data = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [DW-1:0] pop_data;
  logic [CW-1:0] count;
`ifdef SYNC_FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model[$];

  always #5 clk = ~clk;

  sync_fifo #(
    .OPTN_DATA_WIDTH   (DW),
    .OPTN_FIFO_DEPTH   (DEPTH),
    .OPTN_AF_THRESHOLD (AF)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_fifo_flush       (flush),
    .i_fifo_push_valid  (push_valid),
    .o_fifo_push_ready  (push_ready),
    .i_fifo_push_data   (push_data),
    .o_fifo_pop_valid   (pop_valid),
    .i_fifo_pop_ready   (pop_ready),
    .o_fifo_pop_data    (pop_data),
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    .o_fifo_almost_full (almost_full),
`endif
    .o_fifo_count       (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the queue model (valid only out of reset).
  task automatic check_model(input string tag);
    check({tag, "_rdy"}, 32'(push_ready), 32'(model.size() < DEPTH));
    check({tag, "_pv"},  32'(pop_valid),  32'(model.size() > 0));
    check({tag, "_cnt"}, 32'(count),      32'(model.size()));
    if (model.size() > 0) check({tag, "_data"}, 32'(pop_data), 32'(model[0]));
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    check({tag, "_af"}, 32'(almost_full), 32'(model.size() >= AF));
`endif
  endtask

  // One clock cycle: apply inputs, check pre-edge outputs, clock, update model.
  // Called at a point just after a rising edge.
  task automatic step(input logic pv, input logic [DW-1:0] d, input logic pr,
                      input logic fl, input logic r, input bit do_chk);
    bit push_ok, pop_ok;
    push_valid = pv;
    push_data  = d;
    pop_ready  = pr;
    flush      = fl;
    rst        = r;
    push_ok    = pv && (model.size() < DEPTH);
    pop_ok     = pr && (model.size() > 0);
    if (do_chk) check_model("pre");
    @(posedge clk);
    #1;
    if (r || fl) begin
      model.delete();
    end else begin
      if (pop_ok)  void'(model.pop_front());
      if (push_ok) model.push_back(d);
    end
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_flush();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  typedef struct packed {
    logic          pv;
    logic [DW-1:0] d;
    logic          pr;
    logic [CW-1:0] exp_cnt;
    logic          exp_pv;
    logic          exp_rdy;
    logic          chk_d;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Fill 0x11..0x18, attempt a 9th push, then drain in order.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{pv: 1'b1, d: DW'(8'h11 + i), pr: 1'b0, exp_cnt: CW'(i + 1),
                  exp_pv: 1'b1, exp_rdy: (i < 7), chk_d: 1'b1, exp_d: 8'h11};
    vecs[8] = '{pv: 1'b1, d: 8'h99, pr: 1'b0, exp_cnt: CW'(8), exp_pv: 1'b1,
                exp_rdy: 1'b0, chk_d: 1'b1, exp_d: 8'h11};
    for (int k = 0; k < 8; k++)
      vecs[9 + k] = '{pv: 1'b0, d: 8'h00, pr: 1'b1, exp_cnt: CW'(7 - k),
                      exp_pv: (k < 7), exp_rdy: 1'b1, chk_d: (k < 7),
                      exp_d: DW'(8'h12 + k)};

    // Reset
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_cnt", 32'(count), 32'd0);
    check("reset_rdy", 32'(push_ready), 32'd1);
    check("reset_pv",  32'(pop_valid), 32'd0);
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    check("reset_af", 32'(almost_full), 32'd0);
`endif

    // Table: fill, overflow attempt, drain
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].pv, vecs[i].d, vecs[i].pr, 1'b0, 1'b0, 1'b1);
      check($sformatf("vec%0d_cnt", i), 32'(count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_pv", i),  32'(pop_valid), 32'(vecs[i].exp_pv));
      check($sformatf("vec%0d_rdy", i), 32'(push_ready), 32'(vecs[i].exp_rdy));
      if (vecs[i].chk_d)
        check($sformatf("vec%0d_data", i), 32'(pop_data), 32'(vecs[i].exp_d));
    end

    // Push-to-valid latency: not visible in the push cycle, visible next.
    push_valid = 1'b1;
    push_data  = 8'h5A;
    #1;
    check("lat_cycle_n_pv", 32'(pop_valid), 32'd0);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lat_cycle_n1_pv",   32'(pop_valid), 32'd1);
    check("lat_cycle_n1_data", 32'(pop_data), 32'h5A);
    do_flush();

    // Simultaneous push/pop at count=3 for 20 cycles, across pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h21 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] exp_head;
      exp_head = (i < 3) ? DW'(8'h21 + i) : 8'hAA;
      check($sformatf("pp%0d_head", i), 32'(pop_data), 32'(exp_head));
      step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
      check($sformatf("pp%0d_cnt", i), 32'(count), 32'd3);
    end
    do_flush();

    // Flush at count=5 together with a push.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h41 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flush_cnt", 32'(count), 32'd0);
    check("flush_pv",  32'(pop_valid), 32'd0);
    idle();
    check("flush_after_pv",  32'(pop_valid), 32'd0);
    check("flush_after_cnt", 32'(count), 32'd0);

    // Reset at count=4 with a push active, then normal traffic.
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h61 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_mid_cnt", 32'(count), 32'd0);
    check("rst_mid_rdy", 32'(push_ready), 32'd1);
    check("rst_mid_pv",  32'(pop_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h31 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_rd%0d", i), 32'(pop_data), 32'(8'h31 + i));
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    check("rst_drained_pv", 32'(pop_valid), 32'd0);

`ifdef SYNC_FIFO_ALMOST_FULL_EN
    // Almost-full rises exactly at count=6 and falls after one pop.
    do_flush();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("af_push%0d", i), 32'(almost_full), 32'(i >= 6));
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("af_after_pop", 32'(almost_full), 32'd0);
`endif

    // Randomized traffic with phases biased towards filling and draining.
    do_flush();
    for (int i = 0; i < 2000; i++) begin
      int unsigned bias;
      logic pv, pr, fl;
      bias = ((i / 100) % 2 == 0) ? 75 : 25;
      pv = ($urandom_range(0, 99) < bias);
      pr = ($urandom_range(0, 99) < (100 - bias));
      fl = ($urandom_range(0, 127) == 0);
      step(pv, DW'($urandom), pr, fl, 1'b0, 1'b1);
    end
    check_model("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter OPTN_DATA_WIDTH, default 8, meaning entry width in bits.
REQ-002 SHALL have parameter OPTN_FIFO_DEPTH, default 8, meaning entry count; power of two and >= 2.
REQ-003 SHALL have parameter OPTN_AF_THRESHOLD, default 6, meaning almost-full count threshold; used only when SYNC_FIFO_ALMOST_FULL_EN is defined.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_fifo_flush, input, 1 bit: synchronous clear of all entries.
REQ-008 SHALL have port i_fifo_push_valid, input, 1 bit: producer offers data.
REQ-009 SHALL have port o_fifo_push_ready, output, 1 bit: FIFO accepts data.
REQ-010 SHALL have port i_fifo_push_data, input, OPTN_DATA_WIDTH bits: pushed entry.
REQ-011 SHALL have port o_fifo_pop_valid, output, 1 bit: head entry is present.
REQ-012 SHALL have port i_fifo_pop_ready, input, 1 bit: consumer takes the head.
REQ-013 SHALL have port o_fifo_pop_data, output, OPTN_DATA_WIDTH bits: head entry.
REQ-014 SHALL have port o_fifo_count, output, $clog2(OPTN_FIFO_DEPTH)+1 bits: occupancy.
REQ-015 SHALL have port o_fifo_almost_full, output, 1 bit; present only when SYNC_FIFO_ALMOST_FULL_EN is defined.

Function
REQ-016 SHALL store entries in a dual-port RAM with one asynchronous read port and one synchronous write port; the write address is the tail pointer and the read address is the head pointer.
REQ-017 SHALL drive o_fifo_push_ready = !full and o_fifo_pop_valid = !empty, both registered-state-derived with no combinational path from valid/ready inputs.
REQ-018 SHALL treat a push as occurring when i_fifo_push_valid && o_fifo_push_ready; the entry is written at that edge and the tail advances by 1.
REQ-019 SHALL treat a pop as occurring when o_fifo_pop_valid && i_fifo_pop_ready; the head advances by 1 at that edge.
REQ-020 SHALL present o_fifo_pop_data combinationally from the head entry; the value is don't-care while empty.
REQ-021 SHALL have a push-to-pop_valid latency of 1 cycle, with no bypass: a push into an empty FIFO is not visible in the same cycle.
REQ-022 SHALL keep head/tail pointers of $clog2(OPTN_FIFO_DEPTH)+1 bits; empty when pointers are equal; full when the low bits are equal and the MSBs differ; low bits wrap from DEPTH-1 to 0.
REQ-023 SHALL derive count as tail minus head, modulo 2^(width), giving a range of 0..DEPTH.
REQ-024 SHALL complete both operations on a simultaneous push and pop with no count change; since a full FIFO refuses pushes, this occurs only when 0 < count < DEPTH.
REQ-025 SHALL zero both pointers when i_fifo_flush is asserted, overriding any push or pop that cycle; RAM contents are unchanged.
REQ-026 SHALL hold all state when valid or ready is deasserted, and SHALL hold o_fifo_pop_data stable while pop_valid is high and no pop occurs.

Reset
REQ-027 SHALL, with rst high at a clk edge, zero both pointers, with outputs then: push_ready=1, pop_valid=0, count=0, almost_full=0.
REQ-028 SHALL discard in-flight entries on reset mid-operation, including a push in the reset cycle; RAM contents are not cleared.

Configuration
REQ-029 SHALL, with SYNC_FIFO_ALMOST_FULL_EN defined, drive o_fifo_almost_full = (count >= OPTN_AF_THRESHOLD), combinational from the pointers.
REQ-030 SHALL, without SYNC_FIFO_ALMOST_FULL_EN, omit the o_fifo_almost_full port and OPTN_AF_THRESHOLD has no effect.

Structure
REQ-031 SHALL instantiate exactly one sub-module, dp_ram, with OPTN_RAM_DEPTH = OPTN_FIFO_DEPTH, rd_en tied high and wr_en = push.
REQ-032 SHALL keep pointer and count logic local; no new shared package typedefs are needed, and any index-width helper constant belongs in the common library package.

Verification
REQ-033 SHALL cover: DEPTH=8, push 0x11..0x18 with pop_ready=0 -> push_ready falls after the 8th push, count=8; then pop all -> data 0x11..0x18 in order, count=0, pop_valid=0.
REQ-034 SHALL cover: count=3, push 0xAA and pop simultaneously for 20 cycles -> count stays 3 and pointers wrap without data corruption.
REQ-035 SHALL cover: empty FIFO, push 0x5A at cycle N -> pop_valid=1 with data 0x5A at cycle N+1, not at N.
REQ-036 SHALL cover: count=5, flush asserted together with push_valid -> next cycle count=0, pop_valid=0, and the pushed entry is not visible.
REQ-037 SHALL cover: rst asserted at count=4 with push active -> next cycle count=0, push_ready=1; later pushes read back correctly.
REQ-038 SHALL cover, with SYNC_FIFO_ALMOST_FULL_EN and threshold 6: push 6 entries -> almost_full rises exactly on the cycle count=6; pop 1 -> almost_full falls.
